ddc_chan_align: RTL and testbench

DDC_CHAN_ALIGN -- requirements
Module: ddc_chan_align

---
 rtl/ddc_chan_align.sv | 118 +++++++++++
 tb/tb_ddc_chan_align.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddc_chan_align.sv
// ddc_chan_align: tag-checked sample FIFO with delayed burst emission, width reduction and bypass
module ddc_chan_align #(
  parameter int INPUT_WIDTH  = 24,
  parameter int OUTPUT_WIDTH = 24,
  parameter int CH_NUM       = 2,
  parameter int FIFO_DEPTH   = 8,
  parameter int DELAY_CYCLES = 28,
  parameter int ROUND_EN     = 1
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic signed [INPUT_WIDTH-1:0]  Data_In,
  input  logic                           Data_In_Valid,
  input  logic [3:0]                     Data_In_ChIdx,
  input  logic                           Bypass,
  input  logic                           Err_Clr,
  output logic signed [OUTPUT_WIDTH-1:0] Data_Out,
  output logic                           Data_Out_Valid,
  output logic [3:0]                     Data_Out_ChIdx,
  output logic [$clog2(FIFO_DEPTH):0]    Fifo_Level,
  output logic                           Overflow,
  output logic                           Chan_Err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int SH = INPUT_WIDTH - OUTPUT_WIDTH;
  // Rounding offset is zero when truncating or when no bits are dropped, so one datapath serves all modes.
  localparam logic signed [INPUT_WIDTH:0] HALF = (ROUND_EN != 0 && SH > 0) ?
    (INPUT_WIDTH+1)'(1) << (SH > 0 ? SH - 1 : 0) : (INPUT_WIDTH+1)'(0);
  localparam logic signed [INPUT_WIDTH:0] MAXV = {{(SH+2){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  typedef enum logic [1:0] {IDLE, WAIT, EMIT} state_t;
  state_t r_state, w_next;
  logic [7:0] r_cnt;
  logic [LW-1:0] r_level, w_level_nxt;
  logic [AW-1:0] r_wp, r_rp;
  logic [OUTPUT_WIDTH+3:0] r_mem [FIFO_DEPTH];
  logic signed [OUTPUT_WIDTH-1:0] r_dout;
  logic [3:0] r_tag;
  logic r_valid, r_ovf, r_cerr;
  logic signed [INPUT_WIDTH:0] w_sum, w_shr;
  logic signed [OUTPUT_WIDTH-1:0] w_conv;
  logic w_tag_ok, w_take, w_full, w_pop, w_push, w_drop, w_byp;
  assign w_sum = {Data_In[INPUT_WIDTH-1], Data_In} + HALF;
  assign w_shr = w_sum >>> SH;
  assign w_conv = (w_shr > MAXV) ? MAXV[OUTPUT_WIDTH-1:0] : w_shr[OUTPUT_WIDTH-1:0];
  assign w_tag_ok = Data_In_ChIdx != 4'd0 && Data_In_ChIdx <= 4'(CH_NUM);
  assign w_take = Data_In_Valid && w_tag_ok && !Bypass;
  assign w_byp = Data_In_Valid && w_tag_ok && Bypass;
  assign w_full = r_level == LW'(FIFO_DEPTH);
  assign w_pop = r_state == EMIT && r_level != '0 && !Bypass;
  assign w_push = w_take && (!w_full || w_pop);
  assign w_drop = w_take && w_full && !w_pop;
  assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
  assign Data_Out = r_dout;
  assign Data_Out_Valid = r_valid;
  assign Data_Out_ChIdx = r_tag;
  assign Fifo_Level = r_level;
  assign Overflow = r_ovf;
  assign Chan_Err = r_cerr;
  // Next state: bypass forces idle; bursts continue while data remains after each pop.
  always_comb begin
    w_next = r_state;
    if (Bypass) w_next = IDLE;
    else if (r_state == IDLE) w_next = (r_level != '0) ? WAIT : IDLE;
    else if (r_state == WAIT) w_next = (r_cnt == 8'(DELAY_CYCLES)) ? EMIT : WAIT;
    else w_next = (w_level_nxt != '0) ? EMIT : IDLE;
  end
  // State register and delay counter, counting only while waiting.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_cnt <= 8'd0;
    end else begin
      r_state <= w_next;
      r_cnt <= (r_state == WAIT && !Bypass) ? r_cnt + 8'd1 : 8'd0;
    end
  end
  // Sample storage; contents are discarded by resetting the pointers.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wp] <= {w_conv, Data_In_ChIdx};
  end
  // Pointers and occupancy, flushed by reset or while bypassing.
  always_ff @(posedge CLK) begin
    if (!nRST || Bypass) begin
      r_level <= '0;
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      r_level <= w_level_nxt;
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
    end
  end
  // Output register: bypass path or FIFO head, held between pulses.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_valid <= 1'b0;
      r_dout <= '0;
      r_tag <= 4'd0;
    end else begin
      r_valid <= Bypass ? w_byp : w_pop;
      if (w_byp) begin
        r_dout <= w_conv;
        r_tag <= Data_In_ChIdx;
      end else if (w_pop) {r_dout, r_tag} <= r_mem[r_rp];
    end
  end
  // Sticky error flags; a new event wins over a clear.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_ovf <= 1'b0;
      r_cerr <= 1'b0;
    end else begin
      r_ovf <= w_drop || (r_ovf && !Err_Clr);
      r_cerr <= (Data_In_Valid && !w_tag_ok) || (r_cerr && !Err_Clr);
    end
  end
endmodule

// File: tb/tb_ddc_chan_align.sv
// tb_ddc_chan_align: vector table, directed corner sequences and timestamp-model random check
module tb_ddc_chan_align;
  logic clk = 0, rst_n = 0, vld = 0, byp = 0, clr = 0;
  logic [3:0] tag = 0;
  logic [23:0] din = 0;
  logic [23:0] o1_d;
  logic o1_v, o1_ovf, o1_cerr;
  logic [3:0] o1_c, o1_l;
  logic [15:0] o2_d;
  logic o2_v, o2_ovf, o2_cerr;
  logic [3:0] o2_c;
  logic [2:0] o2_l;
  int checks = 0, errors = 0;
  int first, pulses, peak, pop, nout, nout2;
  logic [23:0] sd;
  logic [3:0] sc;
  logic v, ok, acc, cl, ovf_m, cerr_m;
  logic [3:0] c, last_c;
  logic [23:0] d;
  logic [15:0] last_d;
  int q_o[$];
  logic [15:0] q_d[$];
  logic [3:0] q_c[$];
  int ge[$];
  logic [15:0] gd[$];
  logic [3:0] gc[$];
  typedef struct {logic [23:0] din; logic [3:0] tag; logic [15:0] exp;} vec_t;
  vec_t tbl [8];
  ddc_chan_align dut1 (
    .CLK(clk), .nRST(rst_n), .Data_In(din), .Data_In_Valid(vld), .Data_In_ChIdx(tag),
    .Bypass(byp), .Err_Clr(clr), .Data_Out(o1_d), .Data_Out_Valid(o1_v),
    .Data_Out_ChIdx(o1_c), .Fifo_Level(o1_l), .Overflow(o1_ovf), .Chan_Err(o1_cerr)
  );
  ddc_chan_align #(.INPUT_WIDTH(24), .OUTPUT_WIDTH(16), .CH_NUM(2), .FIFO_DEPTH(4),
                   .DELAY_CYCLES(4), .ROUND_EN(1)) dut2 (
    .CLK(clk), .nRST(rst_n), .Data_In(din), .Data_In_Valid(vld), .Data_In_ChIdx(tag),
    .Bypass(byp), .Err_Clr(clr), .Data_Out(o2_d), .Data_Out_Valid(o2_v),
    .Data_Out_ChIdx(o2_c), .Fifo_Level(o2_l), .Overflow(o2_ovf), .Chan_Err(o2_cerr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic vv, input logic [3:0] cc, input logic [23:0] dd);
    vld = vv;
    tag = cc;
    din = dd;
  endtask
  task automatic do_reset();
    rst_n = 0;
    byp = 0;
    clr = 0;
    drive(0, 0, 0);
    step();
    step();
    rst_n = 1;
  endtask
  function automatic logic [15:0] conv(input logic [23:0] x);
    int y;
    y = int'($signed(x));
    y = (y + 128) >>> 8;
    return (y > 32767) ? 16'h7fff : 16'(y);
  endfunction
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{24'h7FFF80, 4'd1, 16'h7FFF};
    tbl[1] = '{24'h000080, 4'd2, 16'h0001};
    tbl[2] = '{24'hFFFF7F, 4'd1, 16'hFFFF};
    tbl[3] = '{24'h000000, 4'd2, 16'h0000};
    tbl[4] = '{24'h00007F, 4'd1, 16'h0000};
    tbl[5] = '{24'h800000, 4'd2, 16'h8000};
    tbl[6] = '{24'hFFFF80, 4'd1, 16'h0000};
    tbl[7] = '{24'h1234C0, 4'd2, 16'h1235};
    do_reset();
    chk("rst_v1", o1_v, 0); chk("rst_d1", o1_d, 0); chk("rst_c1", o1_c, 0);
    chk("rst_l1", o1_l, 0); chk("rst_ovf1", o1_ovf, 0); chk("rst_cerr1", o1_cerr, 0);
    chk("rst_v2", o2_v, 0); chk("rst_l2", o2_l, 0);
    // Single strobe at default parameters: pulse DELAY+3 = 31 edges later.
    drive(1, 1, 24'h000100); step(); drive(0, 0, 0);
    first = -1; pulses = 0; sd = 0; sc = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (o1_v) begin
        pulses++;
        if (first < 0) begin first = k; sd = o1_d; sc = o1_c; end
      end
    end
    chk("lat_single", first, 31); chk("pulses_single", pulses, 1);
    chk("data_single", sd, 24'h000100); chk("tag_single", sc, 1);
    chk("hold_data", o1_d, 24'h000100); chk("hold_tag", o1_c, 1);
    // Width reduction vectors through the bypass path.
    do_reset();
    byp = 1;
    foreach (tbl[i]) begin
      drive(1, tbl[i].tag, tbl[i].din); step();
      chk("tbl_valid", o2_v, 1); chk("tbl_data", o2_d, tbl[i].exp); chk("tbl_tag", o2_c, tbl[i].tag);
    end
    drive(0, 0, 0); step();
    chk("byp_pulse_end", o2_v, 0); chk("byp_hold", o2_d, 16'h1235);
    byp = 0;
    // Back-to-back burst with DELAY_CYCLES=4.
    do_reset();
    drive(1, 1, 24'h000100); step();
    drive(1, 2, 24'h000200); step();
    drive(1, 1, 24'h000300); step();
    drive(0, 0, 0);
    ge.delete(); gd.delete(); gc.delete();
    for (int k = 3; k <= 20; k++) begin
      step();
      if (o2_v) begin ge.push_back(k); gd.push_back(o2_d); gc.push_back(o2_c); end
    end
    chk("burst_count", ge.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("burst_edge", (i < ge.size()) ? ge[i] : -1, 7 + i);
      chk("burst_data", (i < gd.size()) ? gd[i] : 16'hdead, 16'(i + 1));
      chk("burst_tag", (i < gc.size()) ? gc[i] : 4'hf, (i == 1) ? 2 : 1);
    end
    // Overflow: six strobes into a depth-4 FIFO during the delay.
    do_reset();
    peak = 0; pulses = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 24'((i + 1) << 8)); step();
      if (int'(o2_l) > peak) peak = int'(o2_l);
    end
    drive(0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      step();
      if (o2_v) pulses++;
      if (int'(o2_l) > peak) peak = int'(o2_l);
    end
    chk("ovf_outputs", pulses, 4); chk("ovf_peak", peak, 4);
    chk("ovf_flag", o2_ovf, 1); chk("ovf_last_data", o2_d, 16'h0004);
    clr = 1; step(); clr = 0;
    chk("ovf_clear", o2_ovf, 0);
    // Invalid channel tags are dropped and flagged.
    do_reset();
    drive(1, 0, 24'h00AAAA); step();
    drive(1, 3, 24'h00BBBB); step();
    drive(0, 0, 0);
    pulses = 0; peak = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (o1_v) pulses++;
      if (int'(o1_l) > peak) peak = int'(o1_l);
    end
    chk("cerr_outputs", pulses, 0); chk("cerr_level", peak, 0);
    chk("cerr_flag", o1_cerr, 1); chk("cerr_no_ovf", o1_ovf, 0);
    clr = 1; drive(1, 0, 0); step();
    chk("cerr_set_wins", o1_cerr, 1);
    drive(0, 0, 0); step(); clr = 0;
    chk("cerr_clear", o1_cerr, 0);
    // Bypass raised with two entries queued.
    do_reset();
    drive(1, 1, 24'h111111); step();
    drive(1, 2, 24'h222222); step();
    chk("flush_level_pre", o1_l, 2);
    byp = 1; drive(1, 2, 24'h333333); step();
    chk("flush_level", o1_l, 0); chk("flush_byp_v", o1_v, 1);
    chk("flush_byp_d", o1_d, 24'h333333); chk("flush_byp_c", o1_c, 2);
    drive(0, 0, 0); step();
    chk("flush_byp_pulse", o1_v, 0);
    drive(1, 1, 24'h444444); step();
    chk("flush_byp_v2", o1_v, 1); chk("flush_byp_d2", o1_d, 24'h444444);
    drive(0, 0, 0); step(); step();
    byp = 0; pulses = 0;
    for (int k = 0; k < 40; k++) begin step(); if (o1_v) pulses++; end
    chk("flush_no_delayed", pulses, 0); chk("flush_no_ovf", o1_ovf, 0); chk("flush_level_end", o1_l, 0);
    // Reset during the delay drops pending samples.
    do_reset();
    drive(1, 1, 24'h00C0DE); step();
    drive(1, 2, 24'h00BEEF); step();
    drive(0, 0, 0);
    for (int k = 0; k < 10; k++) step();
    rst_n = 0; step(); rst_n = 1;
    pulses = 0;
    for (int k = 0; k < 50; k++) begin step(); if (o1_v) pulses++; end
    chk("rst_mid_outputs", pulses, 0); chk("rst_mid_level", o1_l, 0);
    // Random traffic against a timestamp model of the delayed-burst rules.
    do_reset();
    q_o.delete(); q_d.delete(); q_c.delete();
    ovf_m = 0; cerr_m = 0; last_d = 0; last_c = 0;
    for (int t = 0; t < 600; t++) begin
      v = $urandom_range(0, 9) < 4;
      c = 4'($urandom_range(0, 3));
      d = 24'($urandom);
      cl = $urandom_range(0, 15) == 0;
      drive(v, c, d);
      clr = cl;
      pop = -1; nout = 0;
      foreach (q_o[j]) begin
        if (q_o[j] == t) pop = j;
        if (q_o[j] < t) nout++;
      end
      ok = c != 0 && c <= 2;
      acc = v && ok && ((q_o.size() - nout) < 4 || pop >= 0);
      if (acc) begin
        q_o.push_back((q_o.size() > 0 && t <= q_o[$]) ? q_o[$] + 1 : t + 7);
        q_d.push_back(conv(d));
        q_c.push_back(c);
      end
      ovf_m = (v && ok && !acc) || (ovf_m && !cl);
      cerr_m = (v && !ok) || (cerr_m && !cl);
      if (pop >= 0) begin last_d = q_d[pop]; last_c = q_c[pop]; end
      nout2 = 0;
      foreach (q_o[j]) if (q_o[j] <= t) nout2++;
      step();
      chk("rnd_valid", o2_v, pop >= 0);
      chk("rnd_data", o2_d, last_d);
      chk("rnd_tag", o2_c, last_c);
      chk("rnd_level", o2_l, q_o.size() - nout2);
      chk("rnd_ovf", o2_ovf, ovf_m);
      chk("rnd_cerr", o2_cerr, cerr_m);
    end
    drive(0, 0, 0);
    clr = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
